// File: rtl/uart_mem_bridge.sv
// Purpose : decodes framed UART byte commands (FF, LEN, CMD, [ADDR], [DATA]) and
//           performs byte reads/writes on the SDRAM controller logical port.
// Latency : one response byte per free tx holding slot; one read outstanding at most.
// Backpr. : reads wait for tx_ready, an empty hold and !mem_busy; writes wait for !mem_busy.
//           A second rx byte arriving while a write is still pending sets overrun.
// Ports   : clk/reset (async, active-high); rx_data/rx_strobe from uart_rx;
//           tx_data/tx_strobe/tx_ready to the tx fifo; mem_* to sdram_controller;
//           overrun is sticky until the next FF sync byte.
module uart_mem_bridge #(
  parameter int         ADDR_BITS  = 25,
  parameter int         ADDR_BYTES = 4,
  parameter int         LEN_BYTES  = 2,
  parameter int         TIMEOUT    = 1000000,
  parameter logic [7:0] VERSION    = 8'h32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_strobe,
  output logic [7:0]           tx_data,
  output logic                 tx_strobe,
  input  logic                 tx_ready,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wr_data,
  output logic                 mem_wr_enable,
  output logic                 mem_rd_enable,
  input  logic [7:0]           mem_rd_data,
  input  logic                 mem_rd_ready,
  input  logic                 mem_busy,
  output logic                 overrun
);

  localparam int LEN_BITS = 8 * LEN_BYTES;
  localparam int MAXB     = (ADDR_BYTES > LEN_BYTES) ? ADDR_BYTES : LEN_BYTES;
  localparam int CW       = $clog2(MAXB + 1);
  localparam int TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  localparam logic [7:0] CH_SYNC = 8'hFF;
  localparam logic [7:0] CH_AT   = 8'h40;  // '@'
  localparam logic [7:0] CH_BANG = 8'h21;  // '!'
  localparam logic [7:0] CH_QM   = 8'h3F;  // '?'
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_W    = 8'h57;
  localparam logic [7:0] CH_V    = 8'h56;
  localparam logic [7:0] CH_X    = 8'h58;
  localparam logic [7:0] CH_T    = 8'h54;

  typedef enum logic [3:0] {
    S_IDLE, S_LEN, S_CMD, S_ADDR, S_RD, S_WR, S_WR_ACK, S_VER, S_DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  is_wr_q, is_wr_d;
  logic [7:0]            csum_q, csum_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [7:0]            hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [7:0]            wr_buf_q, wr_buf_d;
  logic                  pend_q, pend_d;
  logic                  rd_out_q, rd_out_d;
  logic                  wr_last_q;
  logic                  overrun_q, overrun_d;
  logic                  ack_ph_q, ack_ph_d;

  logic                  timed, timeout, wr_issue, emit;
  logic [7:0]            emit_byte;

  assign tx_strobe   = hold_vld_q & tx_ready;
  assign tx_data     = hold_q;
  assign mem_addr    = addr_q;
  assign mem_wr_data = wr_buf_q;
  assign overrun     = overrun_q;

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    is_wr_d       = is_wr_q;
    csum_d        = csum_q;
    hold_d        = hold_q;
    hold_vld_d    = hold_vld_q;
    wr_buf_d      = wr_buf_q;
    pend_d        = pend_q;
    rd_out_d      = rd_out_q;
    overrun_d     = overrun_q;
    ack_ph_d      = ack_ph_q;
    mem_rd_enable = 1'b0;
    mem_wr_enable = 1'b0;
    emit          = 1'b0;
    emit_byte     = 8'h00;

    if (tx_strobe) hold_vld_d = 1'b0;

    // Inter-byte timer only runs while a frame is being received.
    timed = (state_q == S_LEN) || (state_q == S_CMD) ||
            (state_q == S_ADDR) || (state_q == S_WR);
    if (!timed || rx_strobe) timer_d = '0;
    else                     timer_d = timer_q + TW'(1);
    timeout = timed && !rx_strobe && (timer_q >= TMAX);

    // A pending write byte is always flushed, even on the abort path (DRAIN).
    // Back-to-back write pulses are never issued.
    wr_issue = ((state_q == S_WR) || (state_q == S_DRAIN)) &&
               pend_q && !mem_busy && !wr_last_q;
    if (wr_issue) begin
      mem_wr_enable = 1'b1;
      addr_d        = addr_q + ADDR_BITS'(1);
      pend_d        = 1'b0;
      if (len_q != '0) len_d = len_q - LEN_BITS'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (rx_strobe) begin
          emit = 1'b1;
          if (rx_data == CH_SYNC) begin
            emit_byte = CH_AT;
            overrun_d = 1'b0;
            len_d     = '0;
            addr_d    = '0;
            cnt_d     = '0;
            state_d   = S_LEN;
          end else begin
            emit_byte = CH_BANG;
          end
        end
      end
      S_LEN: begin
        if (timeout) begin
          emit = 1'b1; emit_byte = CH_T; state_d = S_DRAIN;
        end else if (rx_strobe) begin
          len_d = LEN_BITS'({len_q, rx_data});
          if (cnt_q == CW'(LEN_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = S_CMD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_CMD: begin
        if (timeout) begin
          emit = 1'b1; emit_byte = CH_T; state_d = S_DRAIN;
        end else if (rx_strobe) begin
          if (rx_data == CH_R) begin
            is_wr_d = 1'b0; state_d = S_ADDR;
          end else if (rx_data == CH_W) begin
            is_wr_d = 1'b1; state_d = S_ADDR;
          end else if (rx_data == CH_V) begin
            state_d = S_VER;
          end else begin
            emit = 1'b1; emit_byte = CH_QM; state_d = S_IDLE;
          end
        end
      end
      S_ADDR: begin
        if (timeout) begin
          emit = 1'b1; emit_byte = CH_T; state_d = S_DRAIN;
        end else if (rx_strobe) begin
          // Shifting through an ADDR_BITS register drops the unused upper bits.
          addr_d = ADDR_BITS'({addr_q, rx_data});
          if (cnt_q == CW'(ADDR_BYTES - 1)) begin
            cnt_d = '0;
            if (is_wr_q) begin
              csum_d  = 8'h00;
              ack_ph_d = 1'b0;
              state_d = (len_q == '0) ? S_WR_ACK : S_WR;
            end else begin
              state_d = (len_q == '0) ? S_IDLE : S_RD;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_RD: begin
        if (rd_out_q && mem_rd_ready) begin
          // Hold is guaranteed empty: a read is only issued with an empty hold.
          hold_d     = mem_rd_data;
          hold_vld_d = 1'b1;
          rd_out_d   = 1'b0;
          addr_d     = addr_q + ADDR_BITS'(1);
          len_d      = len_q - LEN_BITS'(1);
          if (len_q == LEN_BITS'(1)) state_d = S_IDLE;
        end else if (!rd_out_q && !hold_vld_q && !mem_busy && tx_ready && (len_q != '0)) begin
          mem_rd_enable = 1'b1;
          rd_out_d      = 1'b1;
        end
      end
      S_WR: begin
        if (wr_issue && (len_q == LEN_BITS'(1))) state_d = S_WR_ACK;
        if (rx_strobe) begin
          if (pend_q) begin
            overrun_d = 1'b1;
            emit      = 1'b1;
            emit_byte = CH_X;
            state_d   = S_DRAIN;
          end else begin
            wr_buf_d = rx_data;
            pend_d   = 1'b1;
            csum_d   = csum_q + rx_data;
          end
        end else if (timeout && !wr_issue) begin
          emit = 1'b1; emit_byte = CH_T; state_d = S_DRAIN;
        end
      end
      S_WR_ACK: begin
        if (!hold_vld_q) begin
          emit = 1'b1;
          if (!ack_ph_q) begin
            emit_byte = CH_W;
            ack_ph_d  = 1'b1;
          end else begin
            emit_byte = csum_q;
            ack_ph_d  = 1'b0;
            state_d   = S_IDLE;
          end
        end
      end
      S_VER: begin
        if (len_q == '0) begin
          state_d = S_IDLE;
        end else if (!hold_vld_q) begin
          emit      = 1'b1;
          emit_byte = VERSION;
          len_d     = len_q - LEN_BITS'(1);
          if (len_q == LEN_BITS'(1)) state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!pend_q || wr_issue) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Responses only ever load an empty hold; a byte that would overwrite is dropped.
    if (emit && !hold_vld_q) begin
      hold_d     = emit_byte;
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      csum_q     <= 8'h00;
      timer_q    <= '0;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      wr_buf_q   <= 8'h00;
      pend_q     <= 1'b0;
      rd_out_q   <= 1'b0;
      wr_last_q  <= 1'b0;
      overrun_q  <= 1'b0;
      ack_ph_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      csum_q     <= csum_d;
      timer_q    <= timer_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      wr_buf_q   <= wr_buf_d;
      pend_q     <= pend_d;
      rd_out_q   <= rd_out_d;
      wr_last_q  <= mem_wr_enable;
      overrun_q  <= overrun_d;
      ack_ph_q   <= ack_ph_d;
    end
  end

endmodule
